// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile_pkg
//  Purpose  : Shared constants for the write-back register file: default
//             data/address widths, register count and the hard-wired zero
//             register index.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

    localparam int DEF_B     = 32;
    localparam int DEF_W     = 5;
    localparam int REG_COUNT = 2 ** DEF_W;
    localparam int ZERO_REG  = 0;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_regfile_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank
//  Purpose  : Raw 2**W x B storage array with one synchronous write port,
//             a synchronous clear, and three asynchronous read ports. It has
//             no knowledge of the zero register or of bypassing; the parent
//             handles both.
//  Ports    : clk, reset          - clock / synchronous active-high clear
//             we, waddr, wdata    - write port (ignored while reset is high)
//             raddr1..3, rdata1..3 - asynchronous read ports
//  Revision : 1.0 - initial release
// ============================================================================
module reg_bank
    import wb_regfile_pkg::*;
#(
    parameter int B = DEF_B,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr1,
    input  logic [W-1:0] raddr2,
    input  logic [W-1:0] raddr3,
    output logic [B-1:0] rdata1,
    output logic [B-1:0] rdata2,
    output logic [B-1:0] rdata3
);

    localparam int C_DEPTH = 2 ** W;

    logic [B-1:0] r_mem [C_DEPTH];

    // Clear takes priority so a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata1 = r_mem[raddr1];
    assign rdata2 = r_mem[raddr2];
    assign rdata3 = r_mem[raddr3];

endmodule : reg_bank
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Write-back stage plus register file. Selects the write-back
//             value (load data or ALU result), commits it to the register
//             bank, and serves two ID-stage read ports with write-first
//             bypass and a debug read port that shows committed state only.
//  Ports    : clk, reset                      - clock / sync active-high reset
//             read_data_in, alu_result_in     - MEM/WB candidate values
//             mux_RegDst_in                   - destination register index
//             wb_RegWrite_in, wb_MemtoReg_in  - write enable / value select
//             read_reg1/2, read_data1/2       - ID-stage operand ports
//             wb_data_out                     - selected write-back value
//             wb_write_active_out             - a real write happens now
//             dbg_addr, dbg_data              - debug read port (no bypass)
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int B = DEF_B,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [B-1:0] read_data_in,
    input  logic [B-1:0] alu_result_in,
    input  logic [W-1:0] mux_RegDst_in,
    input  logic         wb_RegWrite_in,
    input  logic         wb_MemtoReg_in,
    input  logic [W-1:0] read_reg1,
    input  logic [W-1:0] read_reg2,
    output logic [B-1:0] read_data1,
    output logic [B-1:0] read_data2,
    output logic [B-1:0] wb_data_out,
    output logic         wb_write_active_out,
    input  logic [W-1:0] dbg_addr,
    output logic [B-1:0] dbg_data
);

    localparam logic [W-1:0] C_ZERO_ADDR = W'(ZERO_REG);

    logic [B-1:0] w_wb_data;
    logic         w_write_active;
    logic [B-1:0] w_bank_rd1;
    logic [B-1:0] w_bank_rd2;
    logic [B-1:0] w_bank_dbg;

    // Write-back select is never gated by reset; downstream forwarding
    // logic qualifies it with wb_write_active_out itself.
    assign w_wb_data = wb_MemtoReg_in ? read_data_in : alu_result_in;

    // Writes to the zero register, or while reset is held, never happen.
    assign w_write_active = wb_RegWrite_in && (mux_RegDst_in != C_ZERO_ADDR) && !reset;

    assign wb_data_out         = w_wb_data;
    assign wb_write_active_out = w_write_active;

    reg_bank #(
        .B (B),
        .W (W)
    ) u_reg_bank (
        .clk    (clk),
        .reset  (reset),
        .we     (w_write_active),
        .waddr  (mux_RegDst_in),
        .wdata  (w_wb_data),
        .raddr1 (read_reg1),
        .raddr2 (read_reg2),
        .raddr3 (dbg_addr),
        .rdata1 (w_bank_rd1),
        .rdata2 (w_bank_rd2),
        .rdata3 (w_bank_dbg)
    );

    // Operand read: reset forces zero, the zero register is always zero,
    // and an in-flight write to the same index is bypassed (write-first).
    // Both ports use the same rule, so equal addresses give equal data.
    always_comb begin
        read_data1 = w_bank_rd1;
        if (reset || (read_reg1 == C_ZERO_ADDR)) begin
            read_data1 = '0;
        end else if (w_write_active && (read_reg1 == mux_RegDst_in)) begin
            read_data1 = w_wb_data;
        end
    end

    always_comb begin
        read_data2 = w_bank_rd2;
        if (reset || (read_reg2 == C_ZERO_ADDR)) begin
            read_data2 = '0;
        end else if (w_write_active && (read_reg2 == mux_RegDst_in)) begin
            read_data2 = w_wb_data;
        end
    end

    // Debug port shows committed contents only; no bypass.
    always_comb begin
        dbg_data = w_bank_dbg;
        if (reset || (dbg_addr == C_ZERO_ADDR)) begin
            dbg_data = '0;
        end
    end

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Self-checking bench for wb_regfile: directed scenarios plus
//             randomized traffic compared against an array-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    localparam int B = 32;
    localparam int W = 5;
    localparam int N = 2 ** W;

    logic         clk;
    logic         r_reset;
    logic [B-1:0] r_read_data_in;
    logic [B-1:0] r_alu_result_in;
    logic [W-1:0] r_dst;
    logic         r_we;
    logic         r_m2r;
    logic [W-1:0] r_rr1;
    logic [W-1:0] r_rr2;
    logic [W-1:0] r_dbg_addr;
    logic [B-1:0] w_rd1;
    logic [B-1:0] w_rd2;
    logic [B-1:0] w_wb_data;
    logic         w_active;
    logic [B-1:0] w_dbg;

    logic [B-1:0] m_regs [N];
    int           n_cmp;
    int           n_err;

    wb_regfile #(.B(B), .W(W)) dut (
        .clk                 (clk),
        .reset               (r_reset),
        .read_data_in        (r_read_data_in),
        .alu_result_in       (r_alu_result_in),
        .mux_RegDst_in       (r_dst),
        .wb_RegWrite_in      (r_we),
        .wb_MemtoReg_in      (r_m2r),
        .read_reg1           (r_rr1),
        .read_reg2           (r_rr2),
        .read_data1          (w_rd1),
        .read_data2          (w_rd2),
        .wb_data_out         (w_wb_data),
        .wb_write_active_out (w_active),
        .dbg_addr            (r_dbg_addr),
        .dbg_data            (w_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [B-1:0] obs, input logic [B-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs (called just after a falling edge) and let
    // combinational outputs settle.
    task automatic drive(input logic rst, input logic [B-1:0] rd, input logic [B-1:0] alu,
                         input logic [W-1:0] dst, input logic we, input logic m2r,
                         input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [W-1:0] ad);
        r_reset = rst; r_read_data_in = rd; r_alu_result_in = alu; r_dst = dst;
        r_we = we; r_m2r = m2r; r_rr1 = a1; r_rr2 = a2; r_dbg_addr = ad;
        #1;
    endtask

    function automatic logic [B-1:0] exp_read(input logic [W-1:0] a);
        logic [B-1:0] wb;
        logic         act;
        wb  = r_m2r ? r_read_data_in : r_alu_result_in;
        act = r_we && (r_dst != 0) && !r_reset;
        if (r_reset || a == 0) return '0;
        if (act && a == r_dst) return wb;
        return m_regs[a];
    endfunction

    // Compare every output against what the architectural model predicts.
    task automatic check_model(input string tag);
        logic [B-1:0] wb;
        wb = r_m2r ? r_read_data_in : r_alu_result_in;
        check_val({tag, "_wb"},  w_wb_data, wb);
        check_val({tag, "_act"}, B'(w_active), B'(r_we && (r_dst != 0) && !r_reset));
        check_val({tag, "_rd1"}, w_rd1, exp_read(r_rr1));
        check_val({tag, "_rd2"}, w_rd2, exp_read(r_rr2));
        check_val({tag, "_dbg"}, w_dbg, r_reset ? '0 : m_regs[r_dbg_addr]);
    endtask

    // Clock edge: advance the model with the same rules the hardware obeys.
    task automatic tick();
        @(posedge clk);
        if (r_reset) begin
            for (int i = 0; i < N; i++) m_regs[i] = '0;
        end else if (r_we && r_dst != 0) begin
            m_regs[r_dst] = r_m2r ? r_read_data_in : r_alu_result_in;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < N; i++) m_regs[i] = 'x;
        @(negedge clk);

        // Reset with a write request present: nothing may be written.
        drive(1'b1, 32'h0, 32'h1111_1111, 5'd3, 1'b1, 1'b0, 5'd3, 5'd3, 5'd3);
        check_val("rst_act", B'(w_active), '0);
        check_val("rst_rd1", w_rd1, '0);
        check_val("rst_dbg", w_dbg, '0);
        check_val("rst_wb_ungated", w_wb_data, 32'h1111_1111);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd17, 5'd3);
        check_val("post_rst_rd1", w_rd1, '0);
        check_val("post_rst_dbg", w_dbg, '0);
        check_model("post_rst");
        tick();

        // Write then read.
        drive(1'b0, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5);
        check_val("w5_dbg_before", w_dbg, '0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd5);
        check_val("w5_rd1", w_rd1, 32'h0000_1234);
        check_val("w5_dbg", w_dbg, 32'h0000_1234);
        tick();

        // Memory select.
        drive(1'b0, 32'hDEAD_BEEF, 32'h1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9);
        check_val("mem_wb", w_wb_data, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd9);
        check_val("mem_r9", w_rd1, 32'hDEAD_BEEF);
        tick();

        // Same-cycle bypass on both ports; debug still shows the old value.
        drive(1'b0, 32'h0, 32'h0000_0C0C, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7);
        check_val("byp_rd1", w_rd1, 32'hA5A5_A5A5);
        check_val("byp_rd2", w_rd2, 32'hA5A5_A5A5);
        check_val("byp_dbg_old", w_dbg, 32'h0000_0C0C);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
        check_val("byp_dbg_new", w_dbg, 32'hA5A5_A5A5);
        tick();

        // Zero register.
        drive(1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        check_val("z_act", B'(w_active), '0);
        check_val("z_rd1_same", w_rd1, '0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check_val("z_rd1_next", w_rd1, '0);
        tick();

        // Write disabled.
        drive(1'b0, 32'h0, 32'h11, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 32'h0, 32'h55, 5'd3, 1'b0, 1'b0, 5'd3, 5'd3, 5'd3);
        check_val("wd_rd1_same", w_rd1, 32'h11);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd3);
        check_val("wd_r3", w_dbg, 32'h11);
        tick();

        // Randomized traffic, with occasional resets.
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] dst;
            logic [W-1:0] a1;
            logic [W-1:0] a2;
            dst = W'($urandom);
            a1  = ($urandom_range(0, 3) == 0) ? dst : W'($urandom);
            a2  = ($urandom_range(0, 3) == 0) ? a1  : W'($urandom);
            drive(($urandom_range(0, 39) == 0), $urandom, $urandom, dst,
                  ($urandom_range(0, 3) != 0), 1'($urandom), a1, a2, W'($urandom));
            check_model("rand");
            tick();
        end

        // Reset mid-operation: load all registers, then reset over a write.
        for (int i = 1; i < N; i++) begin
            drive(1'b0, 32'h0, $urandom | 32'h1, W'(i), 1'b1, 1'b0, W'(i), 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd31, 5'd4);
        check_model("preload");
        tick();
        drive(1'b1, 32'h0, 32'h77, 5'd4, 1'b1, 1'b0, 5'd4, 5'd4, 5'd4);
        check_val("mid_rst_rd1", w_rd1, '0);
        check_val("mid_rst_rd2", w_rd2, '0);
        check_val("mid_rst_dbg", w_dbg, '0);
        tick();
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, W'(i), W'(N - 1 - i), W'(i));
            check_val("after_rst_rd1", w_rd1, '0);
            check_val("after_rst_dbg", w_dbg, '0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire
